ram_fifo: RTL and testbench
===========================

Name: ram_fifo

Overview:
- Parametrised synchronous FIFO built around a simple dual-port register-file RAM.
- Generalises the fixed 32x4 single-port RAM into a buffer of configurable width and depth.
- Adds independent read/write handshakes, occupancy tracking, full/empty flags and error pulses.
- Sits between a data producer (e.g. the F1/adder datapath generating 4-bit words) and a consumer that drains words at its own rate.

Parameters:
- DATA_W, 4, word width in bits.
- DEPTH, 32, number of words; must be a power of two, at least 2.
- ADDR_W, log2(DEPTH) = 5, pointer width; derived, not overridden by users.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RST  input  1  asynchronous, active-high reset.
- WR_EN  input  1  write request; DIN is sampled on the same edge.
- DIN  input  DATA_W  write data.
- RD_EN  input  1  read request.
- DOUT  output  DATA_W  registered read data.
- DOUT_VALID  output  1  one-cycle strobe: DOUT holds a newly popped word.
- FULL  output  1  COUNT == DEPTH.
- EMPTY  output  1  COUNT == 0.
- COUNT  output  ADDR_W+1  current occupancy, 0..DEPTH.
- OVERFLOW  output  1  one-cycle pulse: a write was rejected.
- UNDERFLOW  output  1  one-cycle pulse: a read was rejected.

Behaviour:
- Reset (RST high, asynchronous):
  - wr_ptr, rd_ptr, COUNT, DOUT, DOUT_VALID, OVERFLOW and UNDERFLOW all go to 0.
  - EMPTY=1, FULL=0.
  - RAM contents are not reset and are undefined to the outside.
- Reset mid-operation: all buffered words are discarded; the first read after release returns the first word written after release.
- Acceptance, evaluated combinationally from current state:
  - rd_ok = RD_EN & ~EMPTY.
  - wr_ok = WR_EN & (~FULL | rd_ok).
  - This allows a simultaneous push and pop when full.
- Write: on posedge with wr_ok, RAM[wr_ptr] <= DIN and wr_ptr increments modulo DEPTH. Natural wrap, since DEPTH is a power of two.
- Read:
  - On posedge with rd_ok, DOUT <= RAM[rd_ptr], rd_ptr increments modulo DEPTH, and DOUT_VALID <= 1.
  - Otherwise DOUT holds its value and DOUT_VALID <= 0.
  - Read latency: one cycle from the accepted RD_EN edge to DOUT/DOUT_VALID.
- COUNT:
  - +1 on wr_ok only; -1 on rd_ok only; unchanged on both or neither.
  - FULL and EMPTY decode combinationally from the registered COUNT.
- Simultaneous push and pop:
  - When EMPTY: the read is rejected (UNDERFLOW pulses), the write is accepted, and COUNT becomes 1. No write-through to DOUT.
  - When FULL: both are accepted, COUNT stays DEPTH, and DOUT returns the oldest word, not DIN.
  - Mid-range: both are accepted and COUNT is unchanged.
- Error pulses (registered, one cycle, not sticky):
  - OVERFLOW <= WR_EN & ~wr_ok.
  - UNDERFLOW <= RD_EN & EMPTY.
- Rejected operations leave pointers, COUNT, RAM and DOUT unchanged.
- Write/read of the same address in the same cycle can only occur with rd_ok while full. The RAM read returns the old (stored) word; the new word is written at the same edge.
- Control state is limited to pointers and COUNT; no explicit FSM beyond EMPTY / PARTIAL / FULL, which are implied by COUNT.

Decomposition:
- Shared package fifo_pkg holds:
  - default constants DATA_W_DEF=4 and DEPTH_DEF=32;
  - a clog2-style function for ADDR_W;
  - the COUNT width expression.
- One sub-module, ram_dp:
  - parametrised DATA_W x DEPTH array;
  - synchronous write port (CLK, WE, WA, DI);
  - asynchronous read port (RA, DO).
  - It generalises the existing RAM storage style.
- ram_fifo instantiates ram_dp and owns the pointers, COUNT, flags and output registers.

Test Plan:
- Reset then idle: assert RST at t=0, release at 12 ns -> EMPTY=1, FULL=0, COUNT=0, DOUT=0, DOUT_VALID=0, no error pulses for 10 cycles.
- Fill and drain in order: write 0x0..0xF then 0x0..0xF (32 words, DIN=i mod 16) -> FULL=1, COUNT=32. Then read 32 times -> DOUT sequence 0,1,..,F,0,..,F, each one cycle after RD_EN with DOUT_VALID=1, and finally EMPTY=1.
- Overflow: from full, WR_EN=1 with DIN=0xA, RD_EN=0 -> OVERFLOW pulses 1 cycle, COUNT stays 32, and the subsequent drain contains no 0xA.
- Underflow with simultaneous write: from empty, WR_EN=1 with DIN=0x5 and RD_EN=1 -> UNDERFLOW pulses, DOUT_VALID=0, COUNT=1. The next read returns 0x5.
- Full push+pop and wrap: fill 32 words, then 40 cycles of WR_EN=RD_EN=1 with an incrementing DIN -> COUNT held at 32, no error pulses, pointers wrap past 31, and output order is strictly FIFO.
- Async reset mid-stream: with COUNT=7, pulse RST between clock edges -> outputs clear immediately without waiting for CLK. A new write of 0x3 followed by a read returns 0x3.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the RAM-backed FIFO.
package fifo_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 32;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2_f(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return clog2_f(depth) + 1;
  endfunction
endpackage

// File: rtl/ram_fifo_if.sv
// Producer/consumer handshake bundle for ram_fifo.
interface ram_fifo_if import fifo_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic              WR_EN;
  logic [DATA_W-1:0] DIN;
  logic              RD_EN;
  logic [DATA_W-1:0] DOUT;
  logic              DOUT_VALID;
  logic              FULL;
  logic              EMPTY;
  logic [CNT_W-1:0]  COUNT;
  logic              OVERFLOW;
  logic              UNDERFLOW;

  modport master (
    output WR_EN, DIN, RD_EN,
    input  DOUT, DOUT_VALID, FULL, EMPTY, COUNT, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  WR_EN, DIN, RD_EN,
    output DOUT, DOUT_VALID, FULL, EMPTY, COUNT, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/ram_dp.sv
// Simple dual-port register file: synchronous write, asynchronous read.
// Storage is intentionally not reset.
module ram_dp import fifo_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = clog2_f(DEPTH)
) (
  input  logic              CLK,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] DI,
  input  logic [ADDR_W-1:0] RA,
  output logic [DATA_W-1:0] DO
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; a same-address read this cycle still sees the old word.
  always_ff @(posedge CLK) begin
    if (WE) mem[WA] <= DI;
  end

  assign DO = mem[RA];
endmodule

// File: rtl/ram_fifo.sv
// Synchronous FIFO over ram_dp: pointers, occupancy, flags, registered
// read data and one-cycle error pulses.
module ram_fifo import fifo_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic      CLK,
  input  logic      RST,
  ram_fifo_if.slave bus
);
  localparam int ADDR_W = clog2_f(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] ram_do, dout_q;
  logic              valid_q, ovf_q, udf_q;
  logic              full, empty, rd_ok, wr_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign rd_ok = bus.RD_EN & ~empty;
  assign wr_ok = bus.WR_EN & (~full | rd_ok);

  ram_dp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .CLK (CLK),
    .WE  (wr_ok),
    .WA  (wr_ptr),
    .DI  (bus.DIN),
    .RA  (rd_ptr),
    .DO  (ram_do)
  );

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (wr_ok && !rd_ok)      count <= count + CNT_W'(1);
      else if (rd_ok && !wr_ok) count <= count - CNT_W'(1);
    end
  end

  // Registered read data, valid strobe and non-sticky error pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (rd_ok) dout_q <= ram_do;
      valid_q <= rd_ok;
      ovf_q   <= bus.WR_EN & ~wr_ok;
      udf_q   <= bus.RD_EN & empty;
    end
  end

  assign bus.DOUT       = dout_q;
  assign bus.DOUT_VALID = valid_q;
  assign bus.FULL       = full;
  assign bus.EMPTY      = empty;
  assign bus.COUNT      = count;
  assign bus.OVERFLOW   = ovf_q;
  assign bus.UNDERFLOW  = udf_q;
endmodule

// File: tb/tb_ram_fifo.sv
// Self-checking bench for ram_fifo against a queue-based reference model.
module tb_ram_fifo;
  import fifo_pkg::*;

  localparam int DW    = 4;
  localparam int DEPTH = 32;
  localparam int CW    = 6;
  localparam int SW    = CW + 5 + DW;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  ram_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  ram_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int vec  = 0;
  int errs = 0;

  // Reference model: a plain queue of stored words plus last popped word.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout;
  logic [SW-1:0] exp_stat;
  wire  [SW-1:0] act_stat = {bus.COUNT, bus.FULL, bus.EMPTY, bus.OVERFLOW,
                             bus.UNDERFLOW, bus.DOUT_VALID, bus.DOUT};

  task automatic model_clear();
    q.delete();
    exp_dout = '0;
    exp_stat = {CW'(0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DW'(0)};
  endtask

  // Apply one clock of stimulus, advance the model, sample 1 ns after the edge.
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r);
    bit rok, wok;
    bus.WR_EN = w;
    bus.DIN   = d;
    bus.RD_EN = r;
    rok = r && (q.size() != 0);
    wok = w && ((q.size() < DEPTH) || rok);
    if (rok) exp_dout = q.pop_front();
    if (wok) q.push_back(d);
    exp_stat = {CW'(q.size()), q.size() == DEPTH, q.size() == 0,
                w && !wok, r && !rok, rok, exp_dout};
    @(posedge CLK);
    #1;
    bus.WR_EN = 1'b0;
    bus.RD_EN = 1'b0;
  endtask

  task automatic test_reset();
    bus.WR_EN = 1'b0;
    bus.RD_EN = 1'b0;
    bus.DIN   = '0;
    RST = 1'b1;
    model_clear();
    #2;
    vec++;
    if (act_stat !== exp_stat) begin
      errs++;
      $display("FAIL reset_asserted: got %h want %h", act_stat, exp_stat);
    end
    #10 RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, '0, 1'b0);
      vec++;
      if (act_stat !== exp_stat) begin
        errs++;
        $display("FAIL reset_idle[%0d]: got %h want %h", i, act_stat, exp_stat);
      end
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, DW'(i % 16), 1'b0);
      vec++;
      if (act_stat !== exp_stat) begin
        errs++;
        $display("FAIL fill[%0d]: got %h want %h", i, act_stat, exp_stat);
      end
    end
    vec++;
    if (bus.FULL !== 1'b1 || bus.COUNT !== CW'(32)) begin
      errs++;
      $display("FAIL fill_full: full=%b count=%0d want full=1 count=32", bus.FULL, bus.COUNT);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, '0, 1'b1);
      vec++;
      if (act_stat !== exp_stat || bus.DOUT !== DW'(i % 16) || bus.DOUT_VALID !== 1'b1) begin
        errs++;
        $display("FAIL drain[%0d]: got %h want %h (dout want %h)", i, act_stat, exp_stat, i % 16);
      end
    end
    vec++;
    if (bus.EMPTY !== 1'b1) begin
      errs++;
      $display("FAIL drain_empty: empty=%b want 1", bus.EMPTY);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(i % 9), 1'b0);
    cyc(1'b1, 4'hA, 1'b0);
    vec++;
    if (act_stat !== exp_stat || bus.OVERFLOW !== 1'b1 || bus.COUNT !== CW'(32)) begin
      errs++;
      $display("FAIL overflow_pulse: got %h want %h", act_stat, exp_stat);
    end
    cyc(1'b0, '0, 1'b0);
    vec++;
    if (act_stat !== exp_stat || bus.OVERFLOW !== 1'b0) begin
      errs++;
      $display("FAIL overflow_clear: got %h want %h", act_stat, exp_stat);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, '0, 1'b1);
      vec++;
      if (act_stat !== exp_stat || bus.DOUT === 4'hA) begin
        errs++;
        $display("FAIL overflow_drain[%0d]: got %h want %h", i, act_stat, exp_stat);
      end
    end
  endtask

  task automatic test_underflow();
    cyc(1'b1, 4'h5, 1'b1);
    vec++;
    if (act_stat !== exp_stat || bus.UNDERFLOW !== 1'b1 || bus.DOUT_VALID !== 1'b0
        || bus.COUNT !== CW'(1)) begin
      errs++;
      $display("FAIL underflow_wr: got %h want %h", act_stat, exp_stat);
    end
    cyc(1'b0, '0, 1'b1);
    vec++;
    if (act_stat !== exp_stat || bus.DOUT !== 4'h5 || bus.DOUT_VALID !== 1'b1) begin
      errs++;
      $display("FAIL underflow_read: got %h want %h", act_stat, exp_stat);
    end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, DW'(i), 1'b1);
      vec++;
      if (act_stat !== exp_stat || bus.COUNT !== CW'(32) || bus.OVERFLOW || bus.UNDERFLOW) begin
        errs++;
        $display("FAIL pushpop[%0d]: got %h want %h", i, act_stat, exp_stat);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, '0, 1'b1);
      vec++;
      if (act_stat !== exp_stat) begin
        errs++;
        $display("FAIL pushpop_drain[%0d]: got %h want %h", i, act_stat, exp_stat);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = (i < 300) ? 70 : 35;
      cyc($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < 50);
      vec++;
      if (act_stat !== exp_stat) begin
        errs++;
        $display("FAIL random[%0d]: got %h want %h", i, act_stat, exp_stat);
      end
    end
  endtask

  task automatic test_async_reset();
    while (q.size() != 0) cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b1, DW'(i + 8), 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 4'hE, 1'b0);
    vec++;
    if (act_stat !== exp_stat || bus.COUNT !== CW'(7)) begin
      errs++;
      $display("FAIL areset_setup: got %h want %h", act_stat, exp_stat);
    end
    #2 RST = 1'b1;
    #1;
    model_clear();
    vec++;
    if (act_stat !== exp_stat) begin
      errs++;
      $display("FAIL areset_immediate: got %h want %h", act_stat, exp_stat);
    end
    #1 RST = 1'b0;
    cyc(1'b1, 4'h3, 1'b0);
    cyc(1'b0, '0, 1'b1);
    vec++;
    if (act_stat !== exp_stat || bus.DOUT !== 4'h3 || bus.DOUT_VALID !== 1'b1) begin
      errs++;
      $display("FAIL areset_reuse: got %h want %h", act_stat, exp_stat);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_full_pushpop();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
